// File: rtl/elevator_pkg.sv
// Shared types and helpers for the elevator scheduler.
// Provides the FSM state codes and an index-width helper.
package elevator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MOVE = 2'b01,
    ST_DOOR = 2'b10
  } state_e;

  // Index width for n items, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/floor_request_scan.sv
// Combinational scan of pending requests relative to a floor.
// In: pending, cur_floor. Out: above, below, here, nearest_up, nearest_dn.
module floor_request_scan
  import elevator_pkg::*;
#(
  parameter int FLOORS  = 3,
  parameter int FLOOR_W = idx_w(FLOORS)
) (
  input  logic [FLOORS-1:0]  pending,
  input  logic [FLOOR_W-1:0] cur_floor,
  output logic               above,
  output logic               below,
  output logic               here,
  output logic [FLOOR_W-1:0] nearest_up,
  output logic [FLOOR_W-1:0] nearest_dn
);

  always_comb begin
    above      = 1'b0;
    below      = 1'b0;
    here       = 1'b0;
    nearest_up = cur_floor;
    nearest_dn = cur_floor;
    // Walking downward leaves the lowest floor above cur_floor.
    for (int i = FLOORS - 1; i >= 0; i--) begin
      if (pending[i] && FLOOR_W'(i) > cur_floor) begin
        above      = 1'b1;
        nearest_up = FLOOR_W'(i);
      end
    end
    // Walking upward leaves the highest floor below cur_floor.
    for (int i = 0; i < FLOORS; i++) begin
      if (pending[i] && FLOOR_W'(i) < cur_floor) begin
        below      = 1'b1;
        nearest_dn = FLOOR_W'(i);
      end
      if (pending[i] && FLOOR_W'(i) == cur_floor)
        here = 1'b1;
    end
  end

endmodule

// File: rtl/elevator_scheduler.sv
// SCAN-order elevator controller: request latch, travel/door timers, FSM.
// In: clk, reset, call, full. Out: cur_floor, target, dir_up, moving, door_open, pending.
module elevator_scheduler
  import elevator_pkg::*;
#(
  parameter int FLOORS       = 3,
  parameter int FLOOR_W      = idx_w(FLOORS),
  parameter int TRAVEL_TICKS = 2,
  parameter int DOOR_TICKS   = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [FLOORS-1:0]  call,
  input  logic               full,
  output logic [FLOOR_W-1:0] cur_floor,
  output logic [FLOOR_W-1:0] target,
  output logic               dir_up,
  output logic               moving,
  output logic               door_open,
  output logic [FLOORS-1:0]  pending
);

  localparam int TW = idx_w(TRAVEL_TICKS);
  localparam int DW = idx_w(DOOR_TICKS);
  localparam logic [TW-1:0] T_LAST = TW'(TRAVEL_TICKS - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DOOR_TICKS - 1);
  localparam logic [FLOOR_W-1:0] F_TOP = FLOOR_W'(FLOORS - 1);

  state_e             state_q, state_d;
  logic [FLOOR_W-1:0] cur_q, cur_d;
  logic               dir_q, dir_d;
  logic [TW-1:0]      tcnt_q, tcnt_d;
  logic [DW-1:0]      dcnt_q, dcnt_d;
  logic [FLOORS-1:0]  pend_q, pend_d;
  logic [FLOORS-1:0]  pend_all;
  logic [FLOOR_W-1:0] floor_nx;

  logic               above, below, here;
  logic [FLOOR_W-1:0] nup, ndn;
  logic               above_n, below_n, here_n;
  logic [FLOOR_W-1:0] nup_n, ndn_n;
  logic               unused_nx;

  assign pend_all = pend_q | call;
  assign floor_nx = dir_q ? cur_q + 1'b1 : cur_q - 1'b1;

  floor_request_scan #(.FLOORS(FLOORS), .FLOOR_W(FLOOR_W)) u_scan (
    .pending    (pend_q),
    .cur_floor  (cur_q),
    .above      (above),
    .below      (below),
    .here       (here),
    .nearest_up (nup),
    .nearest_dn (ndn)
  );

  // Arrival view: next floor against requests including this edge's calls.
  floor_request_scan #(.FLOORS(FLOORS), .FLOOR_W(FLOOR_W)) u_scan_nx (
    .pending    (pend_all),
    .cur_floor  (floor_nx),
    .above      (above_n),
    .below      (below_n),
    .here       (here_n),
    .nearest_up (nup_n),
    .nearest_dn (ndn_n)
  );

  assign unused_nx = ^{nup_n, ndn_n};

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    dir_d   = dir_q;
    tcnt_d  = tcnt_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      ST_IDLE: begin
        tcnt_d = '0;
        dcnt_d = '0;
        if (here) begin
          state_d = ST_DOOR;
        end else if (full) begin
          state_d = ST_IDLE;
        end else if (above && (dir_q || !below)) begin
          state_d = ST_MOVE;
          dir_d   = 1'b1;
        end else if (below) begin
          state_d = ST_MOVE;
          dir_d   = 1'b0;
        end
      end
      ST_MOVE: begin
        if (tcnt_q == T_LAST) begin
          tcnt_d = '0;
          dcnt_d = '0;
          cur_d  = floor_nx;
          if (here_n)
            state_d = ST_DOOR;
          else if (dir_q ? above_n : below_n)
            state_d = ST_MOVE;
          else
            state_d = ST_IDLE;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      ST_DOOR: begin
        // Counter saturates at the end while full holds the door.
        if (dcnt_q == D_LAST) begin
          if (!full) begin
            state_d = ST_IDLE;
            dcnt_d  = '0;
          end
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tcnt_d  = '0;
        dcnt_d  = '0;
      end
    endcase
  end

  // A call at the floor being served is absorbed, not latched.
  always_comb begin
    pend_d = pend_all;
    if (state_d == ST_DOOR) begin
      for (int i = 0; i < FLOORS; i++) begin
        if (FLOOR_W'(i) == cur_d)
          pend_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
      dir_q   <= 1'b1;
      tcnt_q  <= '0;
      dcnt_q  <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      dir_q   <= dir_d;
      tcnt_q  <= tcnt_d;
      dcnt_q  <= dcnt_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    if (dir_q)
      target = above ? nup : (below ? ndn : cur_q);
    else
      target = below ? ndn : (above ? nup : cur_q);
  end

  assign cur_floor = cur_q;
  assign dir_up    = dir_q;
  assign moving    = (state_q == ST_MOVE);
  assign door_open = (state_q == ST_DOOR);
  assign pending   = pend_q;

  // SCAN only keeps moving toward an outstanding request, so no step leaves the shaft.
  a_in_shaft: assert property (
    @(posedge clk) disable iff (reset)
    (state_q == ST_MOVE && tcnt_q == T_LAST)
      |-> (dir_q ? (cur_q != F_TOP) : (cur_q != '0))
  );

endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed bench for elevator_scheduler, FLOORS=4, TRAVEL_TICKS=2, DOOR_TICKS=3.
// Expected values are hand-derived per scenario.
module tb_elevator_scheduler;

  logic       clk;
  logic       reset;
  logic [3:0] call;
  logic       full;
  logic [1:0] cur_floor;
  logic [1:0] target;
  logic       dir_up;
  logic       moving;
  logic       door_open;
  logic [3:0] pending;

  int n_chk;
  int n_pass;

  elevator_scheduler #(
    .FLOORS       (4),
    .FLOOR_W      (2),
    .TRAVEL_TICKS (2),
    .DOOR_TICKS   (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .call      (call),
    .full      (full),
    .cur_floor (cur_floor),
    .target    (target),
    .dir_up    (dir_up),
    .moving    (moving),
    .door_open (door_open),
    .pending   (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    reset  = 1'b1;
    call   = 4'b0000;
    full   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    chk("rst_cur", int'(cur_floor), 0);
    chk("rst_tgt", int'(target), 0);
    chk("rst_dir", int'(dir_up), 1);
    chk("rst_pend", int'(pending), 0);
    chk("rst_mov", int'(moving), 0);
    chk("rst_door", int'(door_open), 0);

    // 1: call at own floor opens the door for 3 cycles
    call = 4'b0001;
    tick();
    chk("t1_pend", int'(pending), 1);
    chk("t1_door0", int'(door_open), 0);
    call = 4'b0000;
    tick();
    chk("t1_door_a", int'(door_open), 1);
    chk("t1_pend_clr", int'(pending), 0);
    tick();
    chk("t1_door_b", int'(door_open), 1);
    tick();
    chk("t1_door_c", int'(door_open), 1);
    chk("t1_cur", int'(cur_floor), 0);
    tick();
    chk("t1_door_end", int'(door_open), 0);

    // 2: floor 0 to 3
    call = 4'b1000;
    tick();
    chk("t2_pend", int'(pending), 8);
    chk("t2_tgt", int'(target), 3);
    chk("t2_mov0", int'(moving), 0);
    call = 4'b0000;
    tick();
    chk("t2_mov1", int'(moving), 1);
    chk("t2_cur0", int'(cur_floor), 0);
    for (int j = 1; j <= 6; j++) begin
      tick();
      chk($sformatf("t2_cur_%0d", j), int'(cur_floor), j / 2);
      chk($sformatf("t2_mov_%0d", j), int'(moving), (j < 6) ? 1 : 0);
    end
    chk("t2_door", int'(door_open), 1);
    chk("t2_pend_clr", int'(pending), 0);
    repeat (3) tick();
    chk("t2_door_end", int'(door_open), 0);
    chk("t2_cur3", int'(cur_floor), 3);

    // 3: reverse from floor 3, stop at 2, continue to 0
    call = 4'b0101;
    tick();
    chk("t3_pend", int'(pending), 5);
    chk("t3_tgt", int'(target), 2);
    chk("t3_dir1", int'(dir_up), 1);
    call = 4'b0000;
    tick();
    chk("t3_mov", int'(moving), 1);
    chk("t3_dir0", int'(dir_up), 0);
    repeat (2) tick();
    chk("t3_cur2", int'(cur_floor), 2);
    chk("t3_door2", int'(door_open), 1);
    chk("t3_pend2", int'(pending), 1);
    repeat (3) tick();
    chk("t3_door2_end", int'(door_open), 0);
    tick();
    chk("t3_mov_dn", int'(moving), 1);
    chk("t3_dir_dn", int'(dir_up), 0);
    repeat (4) tick();
    chk("t3_cur0", int'(cur_floor), 0);
    chk("t3_door0", int'(door_open), 1);
    chk("t3_pend0", int'(pending), 0);
    repeat (3) tick();

    // 4: call for floor 2 on the arrival edge at 2
    call = 4'b1000;
    tick();
    call = 4'b0000;
    tick();
    chk("t4_mov", int'(moving), 1);
    chk("t4_dir", int'(dir_up), 1);
    repeat (2) tick();
    chk("t4_cur1", int'(cur_floor), 1);
    tick();
    call = 4'b0100;
    tick();
    call = 4'b0000;
    chk("t4_cur2", int'(cur_floor), 2);
    chk("t4_door2", int'(door_open), 1);
    chk("t4_pend2", int'(pending), 8);
    repeat (3) tick();
    chk("t4_door2_end", int'(door_open), 0);
    tick();
    chk("t4_mov_up", int'(moving), 1);
    repeat (2) tick();
    chk("t4_cur3", int'(cur_floor), 3);
    chk("t4_door3", int'(door_open), 1);
    repeat (3) tick();

    // idle reset back to floor 0
    reset = 1'b1;
    #1;
    chk("r2_cur", int'(cur_floor), 0);
    chk("r2_dir", int'(dir_up), 1);
    chk("r2_door", int'(door_open), 0);
    reset = 1'b0;

    // 5: full blocks departure
    full = 1'b1;
    call = 4'b0010;
    tick();
    chk("t5_pend", int'(pending), 2);
    call = 4'b0000;
    repeat (2) tick();
    chk("t5_hold", int'(moving), 0);
    chk("t5_pend_h", int'(pending), 2);
    chk("t5_cur0", int'(cur_floor), 0);
    full = 1'b0;
    tick();
    chk("t5_depart", int'(moving), 1);
    repeat (2) tick();
    chk("t5_cur1", int'(cur_floor), 1);
    chk("t5_door1", int'(door_open), 1);
    chk("t5_pend_clr", int'(pending), 0);
    repeat (3) tick();
    chk("t5_door_end", int'(door_open), 0);

    // 6: reset mid-MOVE between floors 1 and 2
    call = 4'b1000;
    tick();
    call = 4'b0000;
    tick();
    chk("t6_mov", int'(moving), 1);
    chk("t6_cur1", int'(cur_floor), 1);
    tick();
    reset = 1'b1;
    #1;
    chk("t6_rst_cur", int'(cur_floor), 0);
    chk("t6_rst_pend", int'(pending), 0);
    chk("t6_rst_mov", int'(moving), 0);
    chk("t6_rst_tgt", int'(target), 0);
    reset = 1'b0;
    tick();
    call = 4'b0001;
    tick();
    chk("t6_pend", int'(pending), 1);
    call = 4'b0000;
    full = 1'b1;
    tick();
    chk("t6_door", int'(door_open), 1);
    repeat (3) tick();
    chk("t6_door_full", int'(door_open), 1);
    full = 1'b0;
    tick();
    chk("t6_door_rel", int'(door_open), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
